// File: rtl/comp_pkg.sv
// Shared types for the nibble-serial magnitude comparator.
//   NIB_W        width of one compared digit
//   state_t      controller states
//   cmp_res_t    encoded compare result, RES_NONE meaning "not decided"
//   res_to_flags decodes a result into {gt, lt, eq}
package comp_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_EQ,
    RES_LT,
    RES_GT
  } cmp_res_t;

  // Returns {gt, lt, eq}; RES_NONE decodes to all zero.
  function automatic logic [2:0] res_to_flags(input cmp_res_t res);
    logic [2:0] flags;
    flags = 3'b000;
    case (res)
      RES_EQ:  flags = 3'b001;
      RES_LT:  flags = 3'b010;
      RES_GT:  flags = 3'b100;
      default: flags = 3'b000;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/nibble_comp.sv
// Combinational unsigned compare of one 4-bit digit.
//   a, b  in   NIB_W  digits to compare
//   eq    out  1      a == b
//   lt    out  1      a <  b
//   gt    out  1      a >  b
module nibble_comp
  import comp_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  assign eq = (a == b);
  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/nibble_serial_comp.sv
// Sequential unsigned magnitude comparator, one nibble per clock, MSB first.
// Acts as the receiving end of a comparator cascade: the casc_* inputs from a
// lower-order stage decide the result only when every nibble is equal.
//
// Configuration macro: COMP_EARLY_EXIT_EN
//   defined   -> stop on the first differing nibble (1..N compare cycles)
//   undefined -> always walk all N nibbles, first difference latched
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    request, sampled only while busy=0
//   a, b       [WIDTH-1:0]   operands, captured on an accepted start
//   casc_eq_in/lt_in/gt_in   lower-stage result, sampled on the index-0 edge
//   busy                     compare in progress
//   done                     one-cycle pulse, flags valid from this cycle
//   a_eq_b, a_ls_b, a_gt_b   one-hot result, held until the next accepted start
module nibble_serial_comp
  import comp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             casc_eq_in,
  input  logic             casc_lt_in,
  input  logic             casc_gt_in,
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             a_ls_b,
  output logic             a_gt_b
);

  localparam int N = WIDTH / NIB_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  cmp_res_t         res_reg, res_next;   // drives the visible flags
`ifndef COMP_EARLY_EXIT_EN
  cmp_res_t         pend_reg, pend_next; // first difference seen so far
  cmp_res_t         first_res;
`endif

  logic [NIB_W-1:0] a_nib [N];
  logic [NIB_W-1:0] b_nib [N];
  logic             nib_eq, nib_lt, nib_gt;
  cmp_res_t         nib_res, casc_res;

  // Slice the operand registers into digits; idx N-1 is the MSB digit.
  for (genvar gi = 0; gi < N; gi++) begin : g_nib
    assign a_nib[gi] = a_reg[gi*NIB_W +: NIB_W];
    assign b_nib[gi] = b_reg[gi*NIB_W +: NIB_W];
  end

  nibble_comp u_nibble_comp (
    .a  (a_nib[idx_reg]),
    .b  (b_nib[idx_reg]),
    .eq (nib_eq),
    .lt (nib_lt),
    .gt (nib_gt)
  );

  // Cascade priority gt > lt > eq also absorbs all-zero and multi-hot inputs.
  assign casc_res = casc_gt_in ? RES_GT : (casc_lt_in ? RES_LT : RES_EQ);
  assign nib_res  = nib_gt ? RES_GT : (nib_lt ? RES_LT : RES_NONE);

`ifndef COMP_EARLY_EXIT_EN
  assign first_res = (pend_reg != RES_NONE) ? pend_reg : nib_res;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= IDX_TOP;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= RES_NONE;
`ifndef COMP_EARLY_EXIT_EN
      pend_reg  <= RES_NONE;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
`ifndef COMP_EARLY_EXIT_EN
      pend_reg  <= pend_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
`ifndef COMP_EARLY_EXIT_EN
    pend_next  = pend_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        // DONE accepts start too, so compares can run back-to-back.
        if (start) begin
          a_next     = a;
          b_next     = b;
          res_next   = RES_NONE;
          idx_next   = IDX_TOP;
`ifndef COMP_EARLY_EXIT_EN
          pend_next  = RES_NONE;
`endif
          state_next = CMP;
        end else if (state_reg == DONE) begin
          state_next = IDLE;
        end
      end
      CMP: begin
`ifdef COMP_EARLY_EXIT_EN
        if (!nib_eq) begin
          res_next   = nib_res;
          state_next = DONE;
        end else if (idx_reg == '0) begin
          res_next   = casc_res;
          state_next = DONE;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
`else
        if (idx_reg == '0) begin
          res_next   = (first_res != RES_NONE) ? first_res : casc_res;
          state_next = DONE;
        end else begin
          pend_next = first_res;
          idx_next  = idx_reg - 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == CMP);
  assign done = (state_reg == DONE);
  assign {a_gt_b, a_ls_b, a_eq_b} = res_to_flags(res_reg);

endmodule

// File: tb/tb_nibble_serial_comp.sv
// Self-checking bench for nibble_serial_comp (WIDTH=16). Follows the
// COMP_EARLY_EXIT_EN macro to pick the expected latency.
module tb_nibble_serial_comp;

  localparam int WIDTH = 16;
  localparam int N = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             casc_eq_in = 1'b0;
  logic             casc_lt_in = 1'b0;
  logic             casc_gt_in = 1'b0;
  logic             busy, done, a_eq_b, a_ls_b, a_gt_b;
  logic [2:0]       flags;

  int errors = 0;
  int checks = 0;

  assign flags = {a_gt_b, a_ls_b, a_eq_b};

  always #5 clk = ~clk;

  nibble_serial_comp #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .casc_eq_in (casc_eq_in),
    .casc_lt_in (casc_lt_in),
    .casc_gt_in (casc_gt_in),
    .busy       (busy),
    .done       (done),
    .a_eq_b     (a_eq_b),
    .a_ls_b     (a_ls_b),
    .a_gt_b     (a_gt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer compare, cascade only on full equality. {gt,lt,eq}
  function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic [2:0] casc);
    if (x > y) return 3'b100;
    if (x < y) return 3'b010;
    if (casc[2]) return 3'b100;
    if (casc[1]) return 3'b010;
    return 3'b001;
  endfunction

  // Edges after the accept edge until done is visible.
  function automatic int ref_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef COMP_EARLY_EXIT_EN
    for (int i = 0; i < N; i++)
      if ((x >> (WIDTH - 4 * (i + 1))) % 16 != (y >> (WIDTH - 4 * (i + 1))) % 16) return i + 1;
`endif
    return N;
  endfunction

  logic [2:0] last_exp = 3'b000;

  // Present a request, let it be accepted, follow it to done.
  // hold=1 keeps start high and scrambles a/b while busy (must be ignored).
  task automatic do_cmp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic [2:0] casc, input bit hold, input string tag);
    int lat;
    bit seen;
    logic [2:0] exp_f;
    int exp_lat;
    exp_f   = ref_flags(ta, tb_v, casc);
    exp_lat = ref_lat(ta, tb_v);
    a = ta;
    b = tb_v;
    {casc_gt_in, casc_lt_in, casc_eq_in} = casc;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    else begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
    end
    check({tag, "_accept_busy"}, 32'(busy), 32'd1);
    check({tag, "_accept_flags"}, 32'(flags), 32'd0);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < N + 3) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else check({tag, "_busy_flags"}, 32'(flags), 32'd0);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_flags"}, 32'(flags), 32'(exp_f));
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
    end
    last_exp = exp_f;
    $display("cmp %s a=%04h b=%04h casc=%03b flags=%03b exp=%03b lat=%0d exp_lat=%0d",
             tag, ta, tb_v, casc, flags, exp_f, lat, exp_lat);
  endtask

  // Idle cycles with start low: done drops, flags hold.
  task automatic idle_hold(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      check({tag, "_hold_flags"}, 32'(flags), 32'(last_exp));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [3:0] nz;
    int k;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_cmp(16'h1234, 16'h1234, 3'b001, 1'b0, "eq1234");
    idle_hold(2, "eq1234");
    do_cmp(16'hA000, 16'h9FFF, 3'b000, 1'b0, "gtA000");
    idle_hold(1, "gtA000");
    do_cmp(16'h1233, 16'h1234, 3'b000, 1'b0, "lt1233");
    do_cmp(16'h0234, 16'h1234, 3'b000, 1'b0, "lt0234");
    do_cmp(16'h5555, 16'h5555, 3'b010, 1'b0, "casc_lt");
    do_cmp(16'h5555, 16'h5555, 3'b110, 1'b0, "casc_gtlt");
    do_cmp(16'h5555, 16'h5555, 3'b000, 1'b0, "casc_zero");
    idle_hold(2, "casc_zero");

    // Reset while idle clears held flags
    #2 rst = 1'b1;
    #1;
    check("rst_idle_flags", 32'(flags), 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    // Reset mid-compare: immediate clear, no done afterwards
    a = 16'h1234; b = 16'h1234; {casc_gt_in, casc_lt_in, casc_eq_in} = 3'b100;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_flags", 32'(flags), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    last_exp = 3'b000;
    idle_hold(N + 2, "post_rst");
    do_cmp(16'hFFFE, 16'hFFFF, 3'b100, 1'b0, "after_rst");

    // start held high: ignored while busy, re-accepted in DONE
    do_cmp(16'h8001, 16'h8002, 3'b000, 1'b1, "hold1");
    do_cmp(16'h4000, 16'h3000, 3'b001, 1'b1, "hold2");
    do_cmp(16'h7777, 16'h7777, 3'b110, 1'b0, "hold3");
    idle_hold(3, "hold3");

    // Randomized compares, biased toward shared MSB prefixes
    for (int it = 0; it < 150; it++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: rb = WIDTH'($urandom);
        1: rb = ra;
        2: begin
          k  = $urandom_range(0, N - 1);
          nz = 4'($urandom_range(1, 15));
          rb = ra ^ (WIDTH'(nz) << (4 * k));
        end
        default: rb = {ra[WIDTH-1:8], 8'($urandom)};
      endcase
      do_cmp(ra, rb, 3'($urandom_range(0, 7)), 1'b0, "rnd");
      if ($urandom_range(0, 1) == 1) idle_hold($urandom_range(1, 2), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
